// File: rtl/proc_pkg.sv
// Shared processor types for the MEM stage: default data-path widths, the
// store-buffer entry layout and a pointer-width helper.
package proc_pkg;

  localparam int SB_ADDR_W = 8;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Store-to-load forwarding compare: scans pending entries from the youngest
// (just behind the tail) to the oldest and returns the first address match.
module sb_match
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 i_en,
  input  sb_entry_t            i_entries [DEPTH],
  input  logic [PTR_W-1:0]     i_tail,
  input  logic [SB_ADDR_W-1:0] i_addr,
  output logic                 o_hit,
  output logic [SB_DATA_W-1:0] o_data
);

  logic [PTR_W-1:0] w_idx;

  // k=1 is the most recently pushed slot; k=DEPTH wraps onto the tail itself,
  // which is the oldest slot when the buffer is full.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_idx = i_tail - PTR_W'(k);
      if (i_en && !o_hit && i_entries[w_idx].valid &&
          (i_entries[w_idx].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues SW operations in a circular FIFO, drains them
// to data memory over req/ack, and forwards pending data to younger loads.
module mem_store_buffer
  import proc_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EX_MEM_MemWrite,
  input  logic                     EX_MEM_MemRead,
  input  logic [ADDR_W-1:0]        EX_MEM_ALUResult,
  input  logic [DATA_W-1:0]        EX_MEM_WriteData,
  output logic                     MEM_Stall,
  output logic                     MEM_FwdHit,
  output logic [DATA_W-1:0]        MEM_FwdData,
  output logic                     DM_WrReq,
  output logic [ADDR_W-1:0]        DM_WrAddr,
  output logic [DATA_W-1:0]        DM_WrData,
  input  logic                     DM_WrAck,
  output logic                     SB_Empty,
  output logic [$clog2(DEPTH):0]   SB_Count
);

  localparam int PTR_W = ptr_w(DEPTH);

  sb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_req;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == (PTR_W+1)'(DEPTH));
  assign w_req  = (r_count != '0);
  // A full buffer never takes the SW, even if the head drains this cycle.
  assign w_push = EX_MEM_MemWrite && !w_full;
  assign w_pop  = w_req && DM_WrAck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1, addr: EX_MEM_ALUResult, data: EX_MEM_WriteData};
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .i_en      (EX_MEM_MemRead),
    .i_entries (r_entries),
    .i_tail    (r_tail),
    .i_addr    (EX_MEM_ALUResult),
    .o_hit     (MEM_FwdHit),
    .o_data    (MEM_FwdData)
  );

  assign MEM_Stall = EX_MEM_MemWrite && w_full;
  assign DM_WrReq  = w_req;
  assign DM_WrAddr = w_req ? r_entries[r_head].addr : '0;
  assign DM_WrData = w_req ? r_entries[r_head].data : '0;
  assign SB_Empty  = !w_req;
  assign SB_Count  = r_count;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of the pending stores.
module tb_mem_store_buffer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] alu_result;
  logic [DW-1:0] write_data;
  logic          mem_stall;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          sb_empty;
  logic [2:0]    sb_count;

  int errors = 0;
  int checks = 0;

  // Pending stores, oldest at index 0, each packed as {addr, data}.
  logic [AW+DW-1:0] exp_q[$];

  mem_store_buffer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM_MemWrite  (mem_write),
    .EX_MEM_MemRead   (mem_read),
    .EX_MEM_ALUResult (alu_result),
    .EX_MEM_WriteData (write_data),
    .MEM_Stall        (mem_stall),
    .MEM_FwdHit       (fwd_hit),
    .MEM_FwdData      (fwd_data),
    .DM_WrReq         (wr_req),
    .DM_WrAddr        (wr_addr),
    .DM_WrData        (wr_data),
    .DM_WrAck         (wr_ack),
    .SB_Empty         (sb_empty),
    .SB_Count         (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every output against what the pending-store list implies.
  task automatic check_model();
    logic          e_hit;
    logic [DW-1:0] e_fwd;
    e_hit = 1'b0;
    e_fwd = '0;
    if (mem_read) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (!e_hit && exp_q[i][AW+DW-1:DW] == alu_result) begin
          e_hit = 1'b1;
          e_fwd = exp_q[i][DW-1:0];
        end
      end
    end
    chk("stall",    64'(mem_stall), 64'(mem_write && exp_q.size() == DEPTH));
    chk("fwd_hit",  64'(fwd_hit),   64'(e_hit));
    chk("fwd_data", 64'(fwd_data),  64'(e_fwd));
    chk("wr_req",   64'(wr_req),    64'(exp_q.size() != 0));
    chk("empty",    64'(sb_empty),  64'(exp_q.size() == 0));
    chk("count",    64'(sb_count),  64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("wr_addr", 64'(wr_addr), 64'(exp_q[0][AW+DW-1:DW]));
      chk("wr_data", 64'(wr_data), 64'(exp_q[0][DW-1:0]));
    end
  endtask

  // One MEM cycle: drive at the falling edge, check, then apply the clock edge.
  task automatic step(input logic wr, input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic ack);
    logic do_push;
    logic do_pop;
    mem_write  = wr;
    mem_read   = rd;
    alu_result = a;
    write_data = d;
    wr_ack     = ack;
    #1;
    check_model();
    do_push = wr && (exp_q.size() < DEPTH);
    do_pop  = ack && (exp_q.size() != 0);
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({a, d});
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 1'b0, '0, '0, ack);
  endtask

  initial begin
    rst        = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_result = '0;
    write_data = '0;
    wr_ack     = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req",   64'(wr_req),   64'(0));
    chk("rst_empty", 64'(sb_empty), 64'(1));
    chk("rst_count", 64'(sb_count), 64'(0));
    chk("rst_addr",  64'(wr_addr),  64'(0));
    chk("rst_data",  64'(wr_data),  64'(0));
    chk("rst_stall", 64'(mem_stall), 64'(0));
    chk("rst_hit",   64'(fwd_hit),  64'(0));
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // SW then LW to the same address, ack held low.
    step(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
    mem_read = 1'b1; alu_result = 8'h10; #1;
    chk("fwd_deadbeef_hit",  64'(fwd_hit),  64'(1));
    chk("fwd_deadbeef_data", 64'(fwd_data), 64'(32'hDEADBEEF));
    mem_read = 1'b0;
    idle(1'b1);
    idle(1'b0);
    chk("drained_empty", 64'(sb_empty), 64'(1));

    // Youngest match wins; neighbouring address misses.
    step(1'b1, 1'b0, 8'h20, 32'h1, 1'b0);
    step(1'b1, 1'b0, 8'h20, 32'h2, 1'b0);
    step(1'b0, 1'b1, 8'h20, 32'h0, 1'b0);
    mem_read = 1'b1; alu_result = 8'h20; #1;
    chk("youngest_data", 64'(fwd_data), 64'(2));
    alu_result = 8'h21; #1;
    chk("miss_hit",  64'(fwd_hit),  64'(0));
    chk("miss_data", 64'(fwd_data), 64'(0));
    mem_read = 1'b0;
    step(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Five SWs with no ack: fifth stalls, one ack pulse lets it in next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 32'(100 + i), 1'b0);
    mem_write = 1'b1; alu_result = 8'h44; write_data = 32'd104; wr_ack = 1'b0; #1;
    chk("full_count", 64'(sb_count),  64'(4));
    chk("full_stall", 64'(mem_stall), 64'(1));
    step(1'b1, 1'b0, 8'h44, 32'd104, 1'b0);
    step(1'b1, 1'b0, 8'h44, 32'd104, 1'b1);
    step(1'b1, 1'b0, 8'h44, 32'd104, 1'b0);
    chk("refill_count", 64'(sb_count), 64'(4));

    // Continuous drain, then refill past the physical end of the array.
    repeat (4) idle(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h50 + i), $urandom, i[0]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 32'h0, 1'b0);
    repeat (5) idle(1'b1);

    // Random traffic over a narrow address window so forwarding hits often.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
           8'(8'h30 + $urandom_range(0, 3)), $urandom, $urandom_range(0, 99) < 45);
    end
    repeat (5) idle(1'b1);

    // Reset in the middle of a drain with three stores pending.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 32'(200 + i), 1'b0);
    idle(1'b1);
    chk("pre_rst_count", 64'(sb_count), 64'(3));
    wr_ack = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req",   64'(wr_req),   64'(0));
    chk("midrst_count", 64'(sb_count), 64'(0));
    chk("midrst_empty", 64'(sb_empty), 64'(1));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

MEM-stage store buffer for the pipelined processor, the write-side counterpart of the LW load path. It accepts SW operations from the EX/MEM register and queues them in a small FIFO. It drains them to the data memory through a req/ack handshake. Loads are serviced by store-to-load forwarding from pending entries, so a LW that follows an SW to the same address always returns the stored value.

## Interface
Parameters:
- ADDR_W, 8: data address width, matching the processor's 8-bit address space
- DATA_W, 32: word width
- DEPTH, 4: number of buffer entries; must be a power of 2, at least 2

Ports (each is name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge
- rst, in, 1: asynchronous, active-low reset
- EX_MEM_MemWrite, in, 1: SW present in MEM this cycle
- EX_MEM_MemRead, in, 1: LW present in MEM this cycle
- EX_MEM_ALUResult, in, ADDR_W: effective address (Rb + SignExtImm)
- EX_MEM_WriteData, in, DATA_W: store data (Rd contents)
- MEM_Stall, out, 1: freeze IF/ID/EX/MEM; the SW is not accepted
- MEM_FwdHit, out, 1: the load address matches a pending entry
- MEM_FwdData, out, DATA_W: data of the youngest matching entry; 0 when there is no hit
- DM_WrReq, out, 1: write request to the data memory
- DM_WrAddr, out, ADDR_W: address of the head entry
- DM_WrData, out, DATA_W: data of the head entry
- DM_WrAck, in, 1: memory accepts the head this cycle
- SB_Empty, out, 1: no pending entries
- SB_Count, out, clog2(DEPTH)+1: number of pending entries

## Operation
Storage:
- Circular FIFO built from a head pointer, a tail pointer and a count register.
- Each entry holds {valid, addr, data}.

Push:
- A push happens when EX_MEM_MemWrite=1 and the buffer is not full.
- The entry is written at the tail, then the tail increments mod DEPTH.

Pop:
- A pop happens when DM_WrReq && DM_WrAck.
- The head entry is invalidated, then the head increments mod DEPTH.

Count rules:
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push only: count+1.
- Pop only: count-1.

Stall:
- MEM_Stall = EX_MEM_MemWrite && (count == DEPTH).
- Stall is combinational.
- There is no push bypass even when an ack arrives in the same cycle. The stalled SW is accepted on the first cycle after the full condition clears.

Write handshake:
- DM_WrReq = !SB_Empty.
- DM_WrAddr and DM_WrData show the head entry.
- These outputs must stay stable while DM_WrReq=1 and DM_WrAck=0.
- DM_WrAck is ignored when DM_WrReq=0.

Forwarding:
- Forwarding is combinational on EX_MEM_ALUResult when EX_MEM_MemRead=1.
- All valid entries are compared; the youngest match (closest to the tail) wins.
- An entry being popped in the current cycle still participates in the compare.
- MEM_FwdHit=0 whenever EX_MEM_MemRead=0.

Load misses:
- A load miss reads the data memory directly.
- This is safe because no pending store targets that address.

Illegal input:
- MemRead and MemWrite both high is illegal.
- The push is still performed and the forward outputs are still computed.

## Timing
Reset (rst=0, asynchronous):
- Count, head and tail are 0 and all valid bits are cleared.
- DM_WrAddr=0, DM_WrData=0, DM_WrReq=0, SB_Empty=1, SB_Count=0.
- MEM_Stall=0 and MEM_FwdHit=0 whenever no inputs are asserted.

Latency:
- Push to DM_WrReq: an SW accepted at edge N raises DM_WrReq after edge N, i.e. during cycle N+1.
- Forwarding: a pushed entry is visible to a load from the cycle after its push edge. An SW and the following LW are one cycle apart in MEM, so the LW always sees it.

Ack timing:
- DM_WrAck may arrive in the first cycle of DM_WrReq.
- The maximum drain rate is one entry per cycle.

Wrap-around:
- Pointers wrap from DEPTH-1 to 0.
- Youngest-match priority is computed relative to the tail, not to the physical index.

Reset mid-operation:
- Pending stores are discarded.
- DM_WrReq drops asynchronously.

## Structure
Shared package `proc_pkg`:
- ADDR_W and DATA_W defaults
- the sb_entry_t struct {valid, addr, data}
- a DEPTH-derived pointer width function

Sub-module `sb_match`:
- Purely combinational.
- Takes the entry vector, the tail pointer and the load address.
- Produces hit and data, using a youngest-first priority scan.

## Test plan
- Reset, then no stimulus: SB_Empty=1, DM_WrReq=0, SB_Count=0, MEM_Stall=0.
- SW to 0x10 with data 0xDEADBEEF and DM_WrAck held 0, followed by LW to 0x10: MEM_FwdHit=1 and MEM_FwdData=0xDEADBEEF; then ack one cycle, and SB_Empty=1 the next cycle.
- Two SWs to 0x20 (0x1, then 0x2) followed by LW to 0x20: MEM_FwdData=0x2; LW to 0x21: MEM_FwdHit=0 and MEM_FwdData=0.
- Five back-to-back SWs with DM_WrAck=0: SB_Count=4 and MEM_Stall=1 on the fifth. With one ack pulse, the fifth SW is accepted the following cycle and SB_Count stays 4.
- Fill, drain with continuous ack and refill past index 3: the wrap is correct, and the drain order matches the push order (address and data checked per write).
- rst asserted mid-drain with 3 entries pending: DM_WrReq=0 immediately, and after release SB_Count=0 with no further writes.
